// File: rtl/btn_pkg.sv
// Shared types and defaults for the button debounce stage.
package btn_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } chan_state_t;

  localparam int DEF_STABLE_SAMPLES = 3;
  localparam int DEF_REPEAT_TICKS   = 8;
  localparam int REPEAT_CNT_W       = 8;

endpackage

// File: rtl/btn_debounce_channel.sv
// One button: two-flop synchroniser, tick-counted debounce FSM, press/release pulses.
// Auto-repeat press pulses are built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);

  logic              s1, s2;
  logic              mismatch;
  logic              rep_fire;
  chan_state_t       state;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  assign mismatch = s2 ^ btn_level;

`ifdef BTN_AUTOREPEAT_EN
  logic [REPEAT_CNT_W-1:0] rep_cnt;
  logic                    rep_step;

  // Counts only on agreeing ticks while held and settled; a pending change freezes it.
  assign rep_step = tick && btn_level && (state == STABLE) && !mismatch;
  assign rep_fire = rep_step && (rep_cnt == REPEAT_CNT_W'(REPEAT_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rep_cnt <= '0;
    else if (!btn_level)
      rep_cnt <= '0;
    else if (rep_fire)
      rep_cnt <= '0;
    else if (rep_step)
      rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= STABLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_press   <= rep_fire;
      btn_release <= 1'b0;
      if (tick) begin
        case (state)
          STABLE: begin
            if (mismatch) begin
              if (STABLE_SAMPLES == 1) begin
                btn_level   <= ~btn_level;
                btn_press   <= ~btn_level;
                btn_release <= btn_level;
              end else begin
                state <= PENDING;
                cnt   <= CNT_W'(1);
              end
            end
          end
          PENDING: begin
            if (!mismatch) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (cnt == CNT_W'(STABLE_SAMPLES - 1)) begin
              btn_level   <= ~btn_level;
              btn_press   <= ~btn_level;
              btn_release <= btn_level;
              state       <= STABLE;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-button debouncer: derives a sampling tick from debounce_clk and fans it to each channel.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int NUM_BTN        = 4,
  parameter int STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               debounce_clk,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  logic dclk_q;
  logic tick;

  // Reset high so a debounce_clk already high at reset release is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dclk_q <= 1'b1;
    else
      dclk_q <= debounce_clk;
  end

  assign tick = debounce_clk & ~dclk_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .REPEAT_TICKS   (REPEAT_TICKS)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed scenarios plus random bounces vs a behavioural model.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int SS = 3;
  localparam int RT = 4;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          debounce_clk = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  button_debouncer #(
    .NUM_BTN        (NB),
    .STABLE_SAMPLES (SS),
    .REPEAT_TICKS   (RT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .debounce_clk (debounce_clk),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: run[c] = consecutive ticks disagreeing with the accepted level.
  logic          m_dq;
  logic [NB-1:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int            run [NB];
  int            rep [NB];
  int            phase = 0;
  bit            last_tick;

  task automatic model_reset();
    m_dq = 1'b1;
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
    for (int c = 0; c < NB; c++) begin
      run[c] = 0;
      rep[c] = 0;
    end
  endtask

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    logic t;
    debounce_clk = ((phase % 8) < 4);
    @(posedge clk);
    t = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      t = debounce_clk & ~m_dq;
      m_dq = debounce_clk;
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < NB; c++) begin
        if (t) begin
          if (m_s2[c] != m_lvl[c]) begin
            run[c]++;
            if (run[c] == SS) begin
              m_lvl[c] = ~m_lvl[c];
              if (m_lvl[c]) m_press[c] = 1'b1;
              else          m_rel[c]   = 1'b1;
              run[c] = 0;
              rep[c] = 0;
            end
          end else if (run[c] != 0) begin
            run[c] = 0;
          end else if (AR && m_lvl[c]) begin
            rep[c]++;
            if (rep[c] == RT) begin
              m_press[c] = 1'b1;
              rep[c] = 0;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
    last_tick = t;
    phase++;
    #1;
    check("level", btn_level, m_lvl);
    check("press", btn_press, m_press);
    check("release", btn_release, m_rel);
    check("excl", btn_press & btn_release, '0);
  endtask

  initial begin
    int n, np, nr, both, one, hold, tk, idx;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (4) step();
    check("rst_level", btn_level, '0);
    rst = 1'b0;
    repeat (8) step();

    // Clean press on bit 0
    btn_raw = 4'b0001;
    np = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_press[0]) np++;
      if (btn_press[3:1] != 3'b000 || btn_release != '0) nr++;
    end
    check_int("press0_count", np, 1);
    check_int("press0_others", nr, 0);
    check("press0_level", btn_level, 4'b0001);

    // Bounce on bit 1: 1,0,1 for one tick window each, then steady 1
    btn_raw[1] = 1'b1; repeat (8) step();
    btn_raw[1] = 1'b0; repeat (8) step();
    check("bounce_not_yet", btn_level, 4'b0001);
    btn_raw[1] = 1'b1;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_press[1]) np++;
    end
    check_int("bounce_press_count", np, 1);
    check("bounce_level", btn_level, 4'b0011);

    // Release bit 0
    btn_raw[0] = 1'b0;
    np = 0; nr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_release[0]) nr++;
      if (btn_press != '0) np++;
    end
    check_int("release0_count", nr, 1);
    check_int("release0_no_press", np, 0);

    // Bits 1 and 3 pressed together (release bit 1 first)
    btn_raw[1] = 1'b0;
    repeat (40) step();
    btn_raw[1] = 1'b1;
    btn_raw[3] = 1'b1;
    both = 0; one = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (btn_press[1] && btn_press[3]) both++;
      else if (btn_press[1] || btn_press[3]) one++;
    end
    check_int("simul_both", both, 1);
    check_int("simul_split", one, 0);

    // Reset mid-PENDING on bit 2, released while debounce_clk is high
    btn_raw = '0;
    repeat (40) step();
    btn_raw[2] = 1'b1;
    n = 0;
    while (run[2] != 2 && n < 100) begin
      step();
      n++;
    end
    check_int("pending_reached", run[2], 2);
    rst = 1'b1;
    model_reset();
    #1;
    check("async_rst_level", btn_level, '0);
    check("async_rst_press", btn_press, '0);
    check("async_rst_release", btn_release, '0);
    step();
    n = 0;
    while ((phase % 8) != 1 && n < 16) begin
      step();
      n++;
    end
    rst = 1'b0;
    step();
    check_int("no_tick_after_rst", int'(last_tick), 0);
    tk = 0; n = 0;
    while (!btn_press[2] && n < 100) begin
      step();
      if (last_tick) tk++;
      n++;
    end
    check_int("ticks_after_rst", tk, 3);
    check("rst_recover_level", btn_level, 4'b0100);

    // Hold bit 2 for 20 sampled ticks
    btn_raw = '0;
    repeat (48) step();
    btn_raw[2] = 1'b1;
    np = 0; tk = 0; idx = 0;
    while (tk < 20 && idx < 400) begin
      step();
      if (idx >= 2 && last_tick) tk++;
      if (btn_press[2]) np++;
      idx++;
    end
    check_int("hold_press_count", np, AR ? 5 : 1);
    btn_raw = '0;
    repeat (40) step();

    // Random bounces, with one mid-run reset
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        btn_raw = NB'($urandom);
        hold = $urandom_range(1, 40);
      end
      hold--;
      if (i == 400) begin
        rst = 1'b1;
        model_reset();
      end
      if (i == 403) rst = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
